xava_result_queue: RTL

- Sits between the xava APU result path and the X-IF result interface.
- Allocates one in-order entry per accepted writeback instruction at issue, holding its id and rd.
- Fills the oldest unfilled entry with apu_result on each apu_rvalid pulse.
- Presents completed entries to the core with a full result_valid/result_ready handshake, so results are never lost when the core stalls; entries killed via the commit interface are discarded.

---
 rtl/xava_result_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/xava_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : xava_result_queue
// Description : In-order result queue between the xava APU result path and
//               the X-IF result interface. Entries are allocated at issue,
//               filled in order by APU results, and drained to the core with
//               a valid/ready handshake. Killed entries are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module xava_result_queue #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [ID_W-1:0]            alloc_id_i,
    input  logic [4:0]                 alloc_rd_i,
    input  logic                       fill_valid_i,
    input  logic [31:0]                fill_data_i,
    input  logic                       commit_valid_i,
    input  logic [ID_W-1:0]            commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [ID_W-1:0]            result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic [31:0]                result_data_o,
    output logic                       result_we_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Entry storage
    logic [ID_W-1:0]  r_id   [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [DEPTH-1:0] r_killed;

    // Pointers carry one wrap bit above the index bits
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_fill;
    logic [PW-1:0]    r_tail;
    logic             r_err;

    logic [PW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_head_idx;
    logic [AW-1:0]    w_fill_idx;
    logic [AW-1:0]    w_tail_idx;
    logic             w_alloc;
    logic             w_fill_ok;
    logic             w_fill_err;
    logic             w_head_filled;
    logic             w_head_killed;
    logic             w_result_valid;
    logic             w_pop;
    logic             w_discard;
    logic             w_kill_req;
    logic [DEPTH-1:0] w_kill_hit;

    assign w_head_idx = r_head[AW-1:0];
    assign w_fill_idx = r_fill[AW-1:0];
    assign w_tail_idx = r_tail[AW-1:0];

    // Occupancy from the pointer difference; the wrap bits separate full from empty
    assign w_count = r_tail - r_head;
    assign w_empty = (r_tail == r_head);
    assign w_full  = (r_tail[AW] != r_head[AW]) && (w_tail_idx == w_head_idx);

    assign w_alloc    = alloc_valid_i && !w_full;
    // The fill target is compared against the registered tail, so an entry
    // allocated in this same cycle can never be filled by it.
    assign w_fill_ok  = fill_valid_i && (r_fill != r_tail);
    assign w_fill_err = fill_valid_i && (r_fill == r_tail);

    assign w_head_filled  = r_filled[w_head_idx];
    assign w_head_killed  = r_killed[w_head_idx];
    assign w_result_valid = !w_empty && w_head_filled && !w_head_killed;
    assign w_pop          = w_result_valid && result_ready_i;
    assign w_discard      = !w_empty && w_head_filled && w_head_killed;

    assign w_kill_req = commit_valid_i && commit_kill_i;

    // Kill match per slot: only occupied, still-unfilled entries can be killed
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_kill
            localparam logic [AW-1:0] c_idx = AW'(i);
            logic [AW-1:0] w_off;
            logic          w_occupied;
            assign w_off         = c_idx - w_head_idx;
            assign w_occupied    = ({1'b0, w_off} < w_count);
            assign w_kill_hit[i] = w_kill_req && w_occupied && !r_filled[i]
                                   && (r_id[i] == commit_id_i);
        end
    endgenerate

    // Entry payload and status bits; alloc clears status of the new tail slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]   <= '0;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_filled <= '0;
            r_killed <= '0;
        end else begin
            r_killed <= r_killed | w_kill_hit;
            if (w_fill_ok) begin
                r_data[w_fill_idx]   <= fill_data_i;
                r_filled[w_fill_idx] <= 1'b1;
            end
            if (w_alloc) begin
                r_id[w_tail_idx]     <= alloc_id_i;
                r_rd[w_tail_idx]     <= alloc_rd_i;
                r_filled[w_tail_idx] <= 1'b0;
                r_killed[w_tail_idx] <= 1'b0;
            end
        end
    end

    // Head, fill and tail pointer advance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_fill <= '0;
            r_tail <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_fill_ok) begin
                r_fill <= r_fill + PW'(1);
            end
            if (w_pop || w_discard) begin
                r_head <= r_head + PW'(1);
            end
        end
    end

    // Sticky error for a fill arriving with no pending entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_fill_err) begin
            r_err <= 1'b1;
        end
    end

    assign alloc_ready_o  = !w_full;
    assign count_o        = w_count;
    assign err_o          = r_err;
    assign result_valid_o = w_result_valid;
    assign result_we_o    = w_result_valid;
    assign result_id_o    = r_id[w_head_idx];
    assign result_rd_o    = r_rd[w_head_idx];
    assign result_data_o  = r_data[w_head_idx];

endmodule
`default_nettype wire
